// File: rtl/svc_cache_axi_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : svc_cache_axi_arb
//  Purpose  : Shares the single CPU-side port of svc_cache_axi between
//             NUM_PORTS valid/ready requesters, one cache operation at a time.
//  Options  : SVC_CACHE_AXI_ARB_FIXED_PRIO_EN selects fixed priority (lowest
//             port index wins) instead of round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module svc_cache_axi_arb #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS-1:0]                 s_ren,
  input  logic [NUM_PORTS-1:0]                 s_wen,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      s_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]      s_wr_data,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]  s_wr_strb,
  output logic [NUM_PORTS-1:0]                 s_ready,
  output logic [DATA_WIDTH-1:0]                s_rd_data,
  output logic [NUM_PORTS-1:0]                 s_rd_valid,
  output logic                                 m_ren,
  output logic                                 m_wen,
  output logic [ADDR_WIDTH-1:0]                m_addr,
  output logic [DATA_WIDTH-1:0]                m_wr_data,
  output logic [DATA_WIDTH/8-1:0]              m_wr_strb,
  input  logic                                 m_ready,
  input  logic [DATA_WIDTH-1:0]                m_rd_data,
  input  logic                                 m_rd_valid
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W      = (NUM_PORTS > 2) ? 2 : 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE_RD = 2'd1;
  localparam logic [1:0] ST_RD_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [PTR_W-1:0]      gnt_q;
  logic                  m_ren_q, m_wen_q;
  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic [DATA_WIDTH-1:0] m_wr_data_q;
  logic [STRB_WIDTH-1:0] m_wr_strb_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [NUM_PORTS-1:0]  rd_valid_q;

  logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_data_arr [NUM_PORTS];
  logic [STRB_WIDTH-1:0] w_strb_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_req;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic                  w_gnt_any;
  logic                  w_grant;
  logic                  w_is_wr;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign w_addr_arr[i] = s_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data_arr[i] = s_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_strb_arr[i] = s_wr_strb[i*STRB_WIDTH +: STRB_WIDTH];
  end

  assign w_req = s_ren | s_wen;

`ifdef SVC_CACHE_AXI_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_req[PTR_W'(k)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = PTR_W'(k);
      end
    end
  end
`else
  // rr_q names the first port searched: the one after the last grant
  logic [PTR_W-1:0] rr_q;

  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_v;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      idx_v = PTR_W'(idx);
      if (!w_gnt_any && w_req[idx_v]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = idx_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else if (w_grant) begin
      if (w_gnt_idx == PTR_W'(NUM_PORTS - 1)) rr_q <= '0;
      else                                    rr_q <= w_gnt_idx + 1'b1;
    end
  end
`endif

  // Gating with rst_n keeps s_ready low while reset is held
  assign w_grant = rst_n && (state_q == ST_IDLE) && m_ready && w_gnt_any;
  assign w_is_wr = s_wen[w_gnt_idx];
  assign s_ready = w_grant ? (NUM_PORTS'(1) << w_gnt_idx) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (w_grant) state_d = w_is_wr ? ST_HOLD : ST_ISSUE_RD;
      ST_ISSUE_RD: state_d = ST_RD_WAIT;
      ST_RD_WAIT:  if (m_rd_valid) state_d = ST_HOLD;
      ST_HOLD:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      m_ren_q     <= 1'b0;
      m_wen_q     <= 1'b0;
      m_addr_q    <= '0;
      m_wr_data_q <= '0;
      m_wr_strb_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= '0;
    end else begin
      state_q    <= state_d;
      m_ren_q    <= w_grant && !w_is_wr;
      m_wen_q    <= w_grant && w_is_wr;
      rd_valid_q <= '0;
      if (w_grant) begin
        gnt_q       <= w_gnt_idx;
        m_addr_q    <= w_addr_arr[w_gnt_idx];
        m_wr_data_q <= w_data_arr[w_gnt_idx];
        m_wr_strb_q <= w_strb_arr[w_gnt_idx];
      end
      if ((state_q == ST_RD_WAIT) && m_rd_valid) begin
        rd_data_q  <= m_rd_data;
        rd_valid_q <= NUM_PORTS'(1) << gnt_q;
      end
    end
  end

  assign m_ren      = m_ren_q;
  assign m_wen      = m_wen_q;
  assign m_addr     = m_addr_q;
  assign m_wr_data  = m_wr_data_q;
  assign m_wr_strb  = m_wr_strb_q;
  assign s_rd_data  = rd_data_q;
  assign s_rd_valid = rd_valid_q;

`ifndef SYNTHESIS
  // A port must never raise read and write together; the arbiter would issue the write
  a_no_rd_and_wr: assert property (@(posedge clk) disable iff (!rst_n) ((s_ren & s_wen) == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_svc_cache_axi_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_svc_cache_axi_arb
//  Purpose  : Randomised self-checking bench for svc_cache_axi_arb with a
//             cache model and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_svc_cache_axi_arb;

  localparam int NP = 2;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] s_ren, s_wen, s_ready, s_rd_valid;
  logic [NP*32-1:0] s_addr, s_wr_data;
  logic [NP*4-1:0]  s_wr_strb;
  logic [31:0]   s_rd_data, m_addr, m_wr_data, m_rd_data;
  logic [3:0]    m_wr_strb;
  logic          m_ren, m_wen, m_ready, m_rd_valid;

  svc_cache_axi_arb #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wr_data(s_wr_data),
    .s_wr_strb(s_wr_strb), .s_ready(s_ready), .s_rd_data(s_rd_data),
    .s_rd_valid(s_rd_valid), .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_wr_strb(m_wr_strb), .m_ready(m_ready),
    .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle time %0t)", tag, act, exp, $time);
    end
  endtask

  // memories: cmem is what the cache holds, rmem is the reference view
  logic [31:0] cmem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction
  function automatic logic [31:0] cmem_rd(input logic [31:0] a);
    return cmem.exists(a) ? cmem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] rmem_rd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  txn_t pq [NP][$];
  bit   acc [NP];

  // reference model state
  int cyc = 0, next_ok = 0, rd_g = 0, rd_port = 0, rv_port = 0, lg = NP - 1;
  int ren_cyc = -1, wen_cyc = -1, rv_cyc = -1;
  bit rd_out = 0;
  logic [31:0] exp_maddr = 0, exp_wdata = 0, exp_rdata = 0, rd_pdata = 0, rv_data = 0;
  logic [3:0]  exp_wstrb = 0;

  // cache model / stimulus knobs
  bit cbusy = 0, rand_bp_en = 0, spur_en = 0;
  int cresp = 0, force_lat = -1, bp_cnt = 0, bp_prev = 0, bp_rel_cyc = -1, rst_phase = 0;
  logic [31:0] caddr = 0;

  int glog_port [$];
  int glog_cyc  [$];
  logic [31:0] rlog [NP][$];
  int wen_cnt = 0;

  function automatic int pick();
`ifdef SVC_CACHE_AXI_ARB_FIXED_PRIO_EN
    for (int p = 0; p < NP; p++) if (pq[p].size() > 0) return p;
`else
    for (int k = 1; k <= NP; k++) if (pq[(lg + k) % NP].size() > 0) return (lg + k) % NP;
`endif
    return -1;
  endfunction

  // per-cycle driver, cache model and reference checks
  initial begin
    txn_t t;
    int   gp;
    logic [NP-1:0] exp_srdy;
    forever begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < NP; p++) if (acc[p]) begin t = pq[p].pop_front(); acc[p] = 0; end
      if (rst_phase == 1)      begin rst_n = 1'b0; rst_phase = 2; end
      else if (rst_phase == 2) begin rst_n = 1'b1; rst_phase = 0; end
      for (int p = 0; p < NP; p++) begin
        if (pq[p].size() > 0) begin
          t = pq[p][0];
          s_ren[p] = !t.wr; s_wen[p] = t.wr;
          s_addr[p*32 +: 32] = t.addr; s_wr_data[p*32 +: 32] = t.data; s_wr_strb[p*4 +: 4] = t.strb;
        end else begin
          s_ren[p] = 1'b0; s_wen[p] = 1'b0;
        end
      end
      m_rd_valid = 1'b0;
      if (cbusy && cyc == cresp) begin
        m_rd_valid = 1'b1; m_rd_data = cmem_rd(caddr); cbusy = 0;
      end else if (!cbusy && spur_en && $urandom_range(0, 7) == 0) begin
        m_rd_valid = 1'b1; m_rd_data = $urandom;
      end
      m_ready = !cbusy && bp_cnt == 0 && !(rand_bp_en && $urandom_range(0, 3) == 0);
      if (bp_cnt == 0 && bp_prev != 0) bp_rel_cyc = cyc;
      bp_prev = bp_cnt;
      if (bp_cnt > 0) bp_cnt--;
      #1;
      if (!rst_n) begin
        chk("rst_s_ready", s_ready, 0);     chk("rst_s_rd_valid", s_rd_valid, 0);
        chk("rst_s_rd_data", s_rd_data, 0); chk("rst_m_ren", m_ren, 0);
        chk("rst_m_wen", m_wen, 0);         chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wr_data", m_wr_data, 0); chk("rst_m_wr_strb", m_wr_strb, 0);
        rd_out = 0; next_ok = 0; lg = NP - 1; ren_cyc = -1; wen_cyc = -1; rv_cyc = -1;
        exp_maddr = 0; exp_rdata = 0;
      end else begin
        if (rd_out && m_rd_valid && cyc >= rd_g + 2) begin
          rv_cyc = cyc + 1; rv_port = rd_port; rv_data = rd_pdata; rd_out = 0; next_ok = cyc + 2;
        end
        if (cyc == rv_cyc) exp_rdata = rv_data;
        gp = -1;
        if (!rd_out && cyc >= next_ok && m_ready) gp = pick();
        exp_srdy = (gp >= 0) ? (NP'(1) << gp) : '0;
        chk("s_ready", s_ready, exp_srdy);
        chk("m_ren", m_ren, cyc == ren_cyc);
        chk("m_wen", m_wen, cyc == wen_cyc);
        chk("m_addr", m_addr, exp_maddr);
        if (cyc == wen_cyc) begin
          chk("m_wr_data", m_wr_data, exp_wdata);
          chk("m_wr_strb", m_wr_strb, exp_wstrb);
        end
        chk("s_rd_valid", s_rd_valid, (cyc == rv_cyc) ? (NP'(1) << rv_port) : '0);
        chk("s_rd_data", s_rd_data, exp_rdata);
        for (int p = 0; p < NP; p++) if (s_rd_valid[p]) rlog[p].push_back(s_rd_data);
        if (m_wen) wen_cnt++;
        if (m_ren) begin
          cbusy = 1; caddr = m_addr;
          cresp = cyc + 1 + ((force_lat >= 0) ? force_lat : int'($urandom_range(0, 3)));
        end
        if (m_wen) cmem[m_addr] = merge(cmem_rd(m_addr), m_wr_data, m_wr_strb);
        if (gp >= 0) begin
          acc[gp] = 1; lg = gp;
          glog_port.push_back(gp); glog_cyc.push_back(cyc);
          t = pq[gp][0];
          exp_maddr = t.addr;
          if (t.wr) begin
            wen_cyc = cyc + 1; exp_wdata = t.data; exp_wstrb = t.strb;
            rmem[t.addr] = merge(rmem_rd(t.addr), t.data, t.strb);
            next_ok = cyc + 2;
          end else begin
            ren_cyc = cyc + 1; rd_out = 1; rd_g = cyc; rd_port = gp; rd_pdata = rmem_rd(t.addr);
          end
        end
      end
    end
  end

  task automatic push(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d; t.strb = s;
    pq[p].push_back(t);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (n < max_cyc && !(pq[0].size() == 0 && pq[1].size() == 0 && !rd_out && !cbusy &&
                            cyc >= next_ok && cyc > rv_cyc && cyc > wen_cyc)) begin
      @(posedge clk); n++;
    end
    if (n >= max_cyc) chk("idle_timeout", 1, 0);
  endtask

  task automatic clear_logs();
    glog_port.delete(); glog_cyc.delete(); rlog[0].delete(); rlog[1].delete(); wen_cnt = 0;
  endtask

  function automatic int gcount(input int p);
    int c = 0;
    foreach (glog_port[i]) if (glog_port[i] == p) c++;
    return c;
  endfunction

  initial begin
    int exp_seq [8];
    int n;
    rst_n = 1'b0; s_ren = '0; s_wen = '0; s_addr = '0; s_wr_data = '0; s_wr_strb = '0;
    m_ready = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0;
    cmem[32'h040] = 32'hCAFEF00D; rmem[32'h040] = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    rst_phase = 2;
    repeat (3) @(posedge clk);

    // single read on port 0
    clear_logs();
    push(0, 0, 32'h040, 0, 0);
    wait_idle(100);
    chk("t1_rd_cnt", rlog[0].size(), 1);
    chk("t1_rd_data", (rlog[0].size() > 0) ? rlog[0][0] : 32'hx, 32'hCAFEF00D);
    chk("t1_p1_quiet", rlog[1].size() + gcount(1), 0);

    // write then read on port 1, then a byte write
    clear_logs();
    push(1, 1, 32'h080, 32'h12345678, 4'hF);
    wait_idle(100);
    chk("t2_wen_cnt", wen_cnt, 1);
    push(1, 0, 32'h080, 0, 0);
    wait_idle(100);
    chk("t2_rd_data", (rlog[1].size() > 0) ? rlog[1][0] : 32'hx, 32'h12345678);
    push(1, 1, 32'h080, 32'h000000AA, 4'h1);
    push(1, 0, 32'h080, 0, 0);
    wait_idle(100);
    chk("t2_byte_data", (rlog[1].size() > 1) ? rlog[1][1] : 32'hx, 32'h123456AA);

    // contention: both ports keep four reads queued
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 32'h200 + 32'(i * 4), 0, 0);
      push(1, 0, 32'h300 + 32'(i * 4), 0, 0);
    end
    wait_idle(400);
    for (int i = 0; i < 8; i++) begin
`ifdef SVC_CACHE_AXI_ARB_FIXED_PRIO_EN
      exp_seq[i] = (i < 4) ? 0 : 1;
`else
      exp_seq[i] = i % 2;
`endif
      chk("t3_grant_order", (glog_port.size() > i) ? glog_port[i] : -1, exp_seq[i]);
    end
    chk("t3_port0_grants", gcount(0), 4);

    // back-pressure: cache not ready for ten cycles
    clear_logs();
    bp_cnt = 10;
    push(0, 0, 32'h0C0, 0, 0);
    wait_idle(200);
    chk("t4_grant_cycle", (glog_cyc.size() > 0) ? glog_cyc[0] : -1, bp_rel_cyc);

    // same-set reads on port 0 with port 1 also requesting
    clear_logs();
    push(0, 0, 32'h000, 0, 0);
    push(0, 0, 32'h100, 0, 0);
    push(1, 0, 32'h1C0, 0, 0);
    wait_idle(300);
    chk("t5_rd0", (rlog[0].size() > 0) ? rlog[0][0] : 32'hx, rmem_rd(32'h000));
    chk("t5_rd1", (rlog[0].size() > 1) ? rlog[0][1] : 32'hx, rmem_rd(32'h100));
    chk("t5_p1_rd", (rlog[1].size() > 0) ? rlog[1][0] : 32'hx, rmem_rd(32'h1C0));

    // reset while a read waits on the cache
    clear_logs();
    force_lat = 8;
    push(0, 0, 32'h0C0, 0, 0);
    n = 0;
    while (n < 100 && !(rd_out && cyc >= rd_g + 3)) begin @(posedge clk); n++; end
    chk("t6_reach_rd_wait", n < 100, 1);
    rst_phase = 1;
    repeat (3) @(posedge clk);
    force_lat = -1;
    wait_idle(100);
    chk("t6_no_stale_valid", rlog[0].size() + rlog[1].size(), 0);
    push(0, 0, 32'h040, 0, 0);
    wait_idle(100);
    chk("t6_rd_after_rst", (rlog[0].size() > 0) ? rlog[0][0] : 32'hx, 32'hCAFEF00D);

    // randomised traffic with back-pressure and stray cache valids
    rand_bp_en = 1; spur_en = 1;
    for (int i = 0; i < 150; i++) begin
      push($urandom_range(0, 1), $urandom_range(0, 1), {23'd0, 3'($urandom_range(0, 7)), 6'd0},
           $urandom, 4'($urandom_range(1, 15)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle(5000);
    rand_bp_en = 0; spur_en = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
